// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle format, arctangent table, gain and FSM states.
// Used by cordic_vectoring and cordic_rotator.
package cordic_pkg;

  localparam int          CORDIC_ANG_W    = 32;
  localparam int          CORDIC_ATAN_N   = 32;
  localparam int          CORDIC_IDX_W    = 5;
  localparam logic [31:0] CORDIC_QUARTER  = 32'h4000_0000;
  // CORDIC gain K ~= 1.64676 as unsigned Q16.16
  localparam logic [31:0] CORDIC_GAIN_Q16 = 32'd107922;

  // round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [31:0] CORDIC_ATAN [0:CORDIC_ATAN_N-1] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/cordic_vectoring_if.sv
// Request/result bundle of cordic_vectoring; the requester drives start/Xin/Yin.
interface cordic_vectoring_if
  import cordic_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ANG_W = CORDIC_ANG_W
);
  logic                    start;
  logic signed [IN_W-1:0]  Xin;
  logic signed [IN_W-1:0]  Yin;
  logic                    ready;
  logic                    done;
  logic        [IN_W+1:0]  mag;
  logic        [ANG_W-1:0] angle;

  modport master (output start, Xin, Yin, input ready, done, mag, angle);
  modport slave  (input start, Xin, Yin, output ready, done, mag, angle);
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup: idx -> ATAN[idx].
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANG_W = CORDIC_ANG_W,
  parameter int IDX_W = CORDIC_IDX_W
) (
  input  logic [IDX_W-1:0] idx,
  output logic [ANG_W-1:0] atan
);

  // table lookup
  always_comb begin
    atan = ANG_W'(CORDIC_ATAN[idx]);
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (X,Y) -> (magnitude * K, atan2 phase).
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ANG_W = CORDIC_ANG_W,
  parameter int ITER  = 16
) (
  input logic               clk,
  input logic               rst,
  cordic_vectoring_if.slave bus
);

  localparam int DW = IN_W + 2;
  localparam int IW = CORDIC_IDX_W;

  cordic_state_e          state_r;
  logic signed [DW-1:0]   x_r, y_r;
  logic        [ANG_W-1:0] z_r;
  logic        [IW-1:0]   idx_r;
  logic                   zero_r;
  logic                   ready_r, done_r;
  logic        [DW-1:0]   mag_r;
  logic        [ANG_W-1:0] angle_r;

  logic signed [DW-1:0]   xe_s, ye_s, x0_s, y0_s, xs_s, ys_s, x_n_s, y_n_s;
  logic        [ANG_W-1:0] z0_s, z_n_s, atan_s;

  cordic_atan_rom #(.ANG_W(ANG_W), .IDX_W(IW)) u_atan_rom (
    .idx  (idx_r),
    .atan (atan_s)
  );

  assign xe_s = {{2{bus.Xin[IN_W-1]}}, bus.Xin};
  assign ye_s = {{2{bus.Yin[IN_W-1]}}, bus.Yin};
  assign xs_s = x_r >>> idx_r;
  assign ys_s = y_r >>> idx_r;

  // fold the left half-plane into the right one by a +-90 degree pre-rotation
  always_comb begin
    x0_s = xe_s;
    y0_s = ye_s;
    z0_s = {ANG_W{1'b0}};
    if (!xe_s[DW-1]) begin
      x0_s = xe_s;
      y0_s = ye_s;
      z0_s = {ANG_W{1'b0}};
    end else if (!ye_s[DW-1]) begin
      x0_s = ye_s;
      y0_s = -xe_s;
      z0_s = ANG_W'(CORDIC_QUARTER);
    end else begin
      x0_s = -ye_s;
      y0_s = xe_s;
      z0_s = {ANG_W{1'b0}} - ANG_W'(CORDIC_QUARTER);
    end
  end

  // one micro-rotation driving y toward zero
  always_comb begin
    x_n_s = x_r;
    y_n_s = y_r;
    z_n_s = z_r;
    if (!y_r[DW-1]) begin
      x_n_s = x_r + ys_s;
      y_n_s = y_r - xs_s;
      z_n_s = z_r + atan_s;
    end else begin
      x_n_s = x_r - ys_s;
      y_n_s = y_r + xs_s;
      z_n_s = z_r - atan_s;
    end
  end

  // control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      x_r     <= {DW{1'b0}};
      y_r     <= {DW{1'b0}};
      z_r     <= {ANG_W{1'b0}};
      idx_r   <= {IW{1'b0}};
      zero_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      mag_r   <= {DW{1'b0}};
      angle_r <= {ANG_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            x_r     <= x0_s;
            y_r     <= y0_s;
            z_r     <= z0_s;
            idx_r   <= {IW{1'b0}};
            zero_r  <= (bus.Xin == {IN_W{1'b0}}) && (bus.Yin == {IN_W{1'b0}});
            ready_r <= 1'b0;
            state_r <= S_ITER;
          end else begin
            ready_r <= 1'b1;
          end
        end
        S_ITER: begin
          x_r   <= x_n_s;
          y_r   <= y_n_s;
          z_r   <= z_n_s;
          idx_r <= idx_r + IW'(1'b1);
          if (idx_r == IW'(ITER - 1)) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_ITER;
          end
        end
        S_DONE: begin
          // a zero vector has no defined phase; report a clean 0/0
          mag_r   <= zero_r ? {DW{1'b0}} : DW'(x_r);
          angle_r <= zero_r ? {ANG_W{1'b0}} : z_r;
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.mag   = mag_r;
  assign bus.angle = angle_r;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: directed vectors, latency, zero input,
// ignored starts while busy and reset abort.
module tb_cordic_vectoring;

  localparam int IN_W  = 16;
  localparam int ANG_W = 32;
  localparam int ITER  = 16;
  localparam int DW    = IN_W + 2;
  // small inputs resolve only ~1/2300 rad, and residual y=-1 keeps growing x
  localparam int ATOL_S = 1 << 20;
  localparam int ATOL_L = 1 << 17;
  localparam int MTOL   = 8;

  typedef struct {
    int id;
    int mag;
    logic [ANG_W-1:0] ang;
    int mtol;
    int atol;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_vectoring_if #(.IN_W(IN_W), .ANG_W(ANG_W)) bus ();

  cordic_vectoring #(.IN_W(IN_W), .ANG_W(ANG_W), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(string name, int id, longint act, longint req, longint tol);
    checks++;
    if (act - req > tol || req - act > tol) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, required %0d (+-%0d)", name, id, act, req, tol);
    end
  endtask

  task automatic check_ang(int id, logic [ANG_W-1:0] act, logic [ANG_W-1:0] req, int tol);
    logic [ANG_W-1:0] diff;
    int d;
    diff = act - req;
    d = int'(signed'(diff));
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL angle[%0d]: got 0x%08h, required 0x%08h (+-%0d)", id, act, req, tol);
    end
  endtask

  // monitor: every done pulse consumes one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, required no pending op", cyc);
      end else begin
        e = sb.pop_front();
        check_int("mag", e.id, longint'(bus.mag), longint'(e.mag), longint'(e.mtol));
        check_ang(e.id, bus.angle, e.ang, e.atol);
        check_int("latency", e.id, longint'(cyc - e.acc), longint'(ITER + 1), 0);
      end
    end
  end

  task automatic wait_ready();
    int k;
    for (k = 0; k < 64; k++) begin
      if (bus.ready) break;
      @(negedge clk);
    end
    check_int("ready_wait", 0, longint'(bus.ready), 1, 0);
  endtask

  task automatic run_op(int id, int x, int y, int mag_e, logic [ANG_W-1:0] ang_e,
                        int mtol, int atol);
    int k;
    wait_ready();
    bus.start = 1'b1;
    bus.Xin   = IN_W'(x);
    bus.Yin   = IN_W'(y);
    @(posedge clk);
    #1;
    sb.push_back('{id: id, mag: mag_e, ang: ang_e, mtol: mtol, atol: atol, acc: cyc});
    @(negedge clk);
    bus.start = 1'b0;
    check_int("busy_ready", id, longint'(bus.ready), 0, 0);
    for (k = 0; k < ITER + 8; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d]: got no done after %0d cycles, required one", id, ITER + 8);
      sb.delete();
    end
  endtask

  initial begin
    int base;
    bus.start = 1'b0;
    bus.Xin   = '0;
    bus.Yin   = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_int("rst_ready", 0, longint'(bus.ready), 1, 0);
    check_int("rst_done",  0, longint'(bus.done), 0, 0);
    check_int("rst_mag",   0, longint'(bus.mag), 0, 0);
    check_int("rst_angle", 0, longint'(bus.angle), 0, 0);

    run_op(0,      0,      0,     0, 32'h0000_0000, 0,    0);
    run_op(1,   1000,      0,  1647, 32'h0000_0000, MTOL, ATOL_S);
    run_op(2,      0,   1000,  1647, 32'h4000_0000, MTOL, ATOL_S);
    run_op(3,  -1000,      0,  1647, 32'h8000_0000, MTOL, ATOL_S);
    run_op(4,   1000,   1000,  2329, 32'h2000_0000, MTOL, ATOL_S);
    run_op(5, -32768, -32768, 76312, 32'hA000_0000, MTOL, ATOL_L);

    repeat (6) @(negedge clk);
    check_int("hold_mag", 5, longint'(bus.mag), 76312, MTOL);
    check_ang(5, bus.angle, 32'hA000_0000, ATOL_L);

    // accepted op, start kept high while busy, then aborted by reset
    wait_ready();
    base = done_seen;
    bus.start = 1'b1;
    bus.Xin   = IN_W'(1000);
    bus.Yin   = IN_W'(1000);
    @(negedge clk);
    bus.Xin = IN_W'(-5);
    bus.Yin = IN_W'(7);
    repeat (5) @(negedge clk);
    check_int("busy_ignored_ready", 6, longint'(bus.ready), 0, 0);
    check_int("busy_hold_mag", 6, longint'(bus.mag), 76312, MTOL);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_int("abort_ready", 6, longint'(bus.ready), 1, 0);
    check_int("abort_done",  6, longint'(bus.done), 0, 0);
    check_int("abort_mag",   6, longint'(bus.mag), 0, 0);
    check_int("abort_angle", 6, longint'(bus.angle), 0, 0);
    repeat (ITER + 6) @(negedge clk);
    check_int("abort_no_done", 6, longint'(done_seen - base), 0, 0);

    run_op(7, 0, 1000, 1647, 32'h4000_0000, MTOL, ATOL_S);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
